// File: rtl/pc_fetch_ctrl.sv
// Program-counter sequencer and single-outstanding instruction fetch handshake.
// Latency: imem_ack cycle -> inst_valid high on the next edge; peak 1 instruction / 2 cycles.
// Backpressure: stall holds inst/inst_pc/pc in S_OUT; no new request issues until consumed.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   stall                        decode cannot take the presented instruction
//   branch_taken/branch_target   redirect (priority over jump)
//   jump/jump_target             redirect
//   imem_req/imem_addr           fetch request, address == pc
//   imem_ack/imem_rdata          fetch completion and data
//   inst_valid/inst/inst_pc      instruction presented to decode
//   pc                           current fetch PC register
//   misalign                     1-cycle pulse on an unaligned redirect target
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//   defined   -> redirect targets have bits [1:0] forced to 0, misalign pulses on
//                any accepted redirect with a non-zero low pair
//   undefined -> targets used as given, misalign tied to 0

module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] pc,
  output logic        misalign
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] inst_nxt;
  logic [31:0] inst_pc_nxt;
  logic        inst_valid_nxt;
  logic        pend, pend_nxt;
  logic [31:0] redir_pc, redir_pc_nxt;

  logic        redirect;
  logic [31:0] tgt_raw;
  logic [31:0] tgt;

  assign redirect = branch_taken | jump;
  assign tgt_raw  = branch_taken ? branch_target : jump_target;

`ifdef PC_ALIGN_CHECK_EN
  logic redir_accept;
  logic misalign_q;

  assign tgt = {tgt_raw[31:2], 2'b00};
  // Every non-idle state either applies or buffers a redirect.
  assign redir_accept = redirect & (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= redir_accept & (|tgt_raw[1:0]);
    end
  end

  assign misalign = misalign_q;
`else
  assign tgt      = tgt_raw;
  assign misalign = 1'b0;
`endif

  // The request is a pure function of state; the address is the PC register,
  // which only changes on an ack or outside S_REQ, so it stays stable while waiting.
  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      inst       <= 32'h0;
      inst_pc    <= 32'h0;
      inst_valid <= 1'b0;
      pend       <= 1'b0;
      redir_pc   <= 32'h0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      inst       <= inst_nxt;
      inst_pc    <= inst_pc_nxt;
      inst_valid <= inst_valid_nxt;
      pend       <= pend_nxt;
      redir_pc   <= redir_pc_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    inst_nxt       = inst;
    inst_pc_nxt    = inst_pc;
    inst_valid_nxt = inst_valid;
    pend_nxt       = pend;
    redir_pc_nxt   = redir_pc;

    case (state)
      S_IDLE: begin
        // Redirects are ignored here; the first fetch always goes to pc.
        state_nxt = S_REQ;
      end

      S_REQ: begin
        if (!imem_ack) begin
          // The request cannot be withdrawn, so remember the latest target
          // and keep the address stable until the memory answers.
          if (redirect) begin
            redir_pc_nxt = tgt;
            pend_nxt     = 1'b1;
          end
        end else if (pend || redirect) begin
          // Returned word belongs to the stale path: drop it and re-fetch.
          pc_nxt   = redirect ? tgt : redir_pc;
          pend_nxt = 1'b0;
        end else begin
          inst_nxt       = imem_rdata;
          inst_pc_nxt    = pc;
          inst_valid_nxt = 1'b1;
          pc_nxt         = pc + PC_STEP;
          state_nxt      = S_OUT;
        end
      end

      S_OUT: begin
        if (redirect) begin
          // Redirect beats stall: the held instruction is on the wrong path.
          inst_valid_nxt = 1'b0;
          pc_nxt         = tgt;
          state_nxt      = S_REQ;
        end else if (!stall) begin
          inst_valid_nxt = 1'b0;
          state_nxt      = S_REQ;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
